ir_receiver_bus: RTL and testbench

Memory-mapped IR command receiver, the receive-side counterpart of the IR transmitter peripheral. It measures burst and gap widths on a demodulated IR input and decodes a start burst plus 4 command bits (MSB first). The decoded command is latched into a bus-readable register and an interrupt is raised. It sits on the shared 8-bit CPU bus as a responder alongside the timer, mouse, VGA, seven-segment and LED peripherals.

---
 rtl/ir_receiver_bus.sv | 204 ++++++++++++++++++++
 tb/tb_ir_receiver_bus.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_receiver_bus.sv
// rtl/ir_receiver_bus.sv - memory-mapped IR command receiver (start burst + 4 data bits)
module ir_receiver_bus #(
    parameter logic [7:0] BASE_ADDR = 8'hA0,
    parameter int         TICK_DIV  = 100,
    parameter int         START_MIN = 2000,
    parameter int         BIT_MIN   = 200,
    parameter int         ONE_MIN   = 800,
    parameter int         BIT_MAX   = 1500,
    parameter int         GAP_MAX   = 1500
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    input  logic       IR_RX,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK
);

    localparam int          PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [15:0] START_MIN_C = 16'(START_MIN);
    localparam logic [15:0] BIT_MIN_C   = 16'(BIT_MIN);
    localparam logic [15:0] ONE_MIN_C   = 16'(ONE_MIN);
    localparam logic [15:0] BIT_MAX_C   = 16'(BIT_MAX);
    localparam logic [15:0] GAP_MAX_C   = 16'(GAP_MAX);
    localparam logic [7:0]  CTRL_ADDR   = 8'(BASE_ADDR + 8'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_GAP,
        S_BIT,
        S_DONE
    } state_t;

    // Input synchroniser and measurement prescaler
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;
    logic          carrier;

    // Frame decoder
    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [1:0]    bit_idx_q, bit_idx_d;
    logic [3:0]    shift_q, shift_d;

    // Register file and bus response
    logic [3:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;
    logic          irq_en_q, irq_en_d;
    logic          raise_q, raise_d;
    logic          rd_en_q, rd_en_d;
    logic [7:0]    rd_data_q, rd_data_d;

    logic          done;
    logic          busy;
    logic          rd_hit_data;
    logic          rd_hit_stat;
    logic          wr_ctrl;
    logic [5:0]    unused_bus_bits;

    // Synchronise IR_RX (carrier is active-low) and divide the clock into ticks
    always_comb begin
        sync1_d = IR_RX;
        sync2_d = sync1_q;
        carrier = ~sync2_q;
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : PW'(presc_q + PW'(1));
    end

    // Decoder next state, bit shifter and per-state width counter
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            S_IDLE: begin
                if (carrier) state_d = S_START;
            end
            S_START: begin
                if (!carrier) begin
                    if (cnt_q >= START_MIN_C) begin
                        state_d   = S_GAP;
                        bit_idx_d = 2'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (carrier)                state_d = S_BIT;
                else if (cnt_q > GAP_MAX_C) state_d = S_IDLE;
            end
            S_BIT: begin
                if (cnt_q > BIT_MAX_C) begin
                    state_d = S_IDLE;
                end else if (!carrier) begin
                    if (cnt_q < BIT_MIN_C) begin
                        state_d = S_IDLE;
                    end else begin
                        shift_d = {shift_q[2:0], (cnt_q >= ONE_MIN_C)};
                        if (bit_idx_q == 2'd3) begin
                            state_d = S_DONE;
                        end else begin
                            bit_idx_d = bit_idx_q + 2'd1;
                            state_d   = S_GAP;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Every state measures its own width from zero
        if (state_d != state_q)               cnt_d = 16'd0;
        else if (tick && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
        else                                  cnt_d = cnt_q;
    end

    // Bus decode, status flags and interrupt; a completing frame overrides clears and acks
    always_comb begin
        done        = (state_q == S_DONE);
        busy        = (state_q != S_IDLE);
        rd_hit_data = !BUS_WE && (BUS_ADDR == BASE_ADDR);
        rd_hit_stat = !BUS_WE && (BUS_ADDR == CTRL_ADDR);
        wr_ctrl     = BUS_WE && (BUS_ADDR == CTRL_ADDR);

        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        irq_en_d  = irq_en_q;
        raise_d   = raise_q;

        rd_en_d   = rd_hit_data || rd_hit_stat;
        rd_data_d = rd_hit_data ? {4'b0, data_q}
                                : {4'b0, irq_en_q, busy, overrun_q, valid_q};

        if (wr_ctrl) irq_en_d = BUS_DATA[0];

        if (rd_hit_data || (wr_ctrl && BUS_DATA[1])) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        if (done) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q) overrun_d = 1'b1;
        end

        if (BUS_INTERRUPT_ACK) raise_d = 1'b0;
        if (done && irq_en_q)  raise_d = 1'b1;
    end

    assign unused_bus_bits     = BUS_DATA[7:2];
    assign BUS_DATA            = rd_en_q ? rd_data_q : 8'bz;
    assign BUS_INTERRUPT_RAISE = raise_q;

    // State registers; synchroniser resets to "no carrier"
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            presc_q   <= '0;
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            bit_idx_q <= 2'd0;
            shift_q   <= 4'd0;
            data_q    <= 4'd0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            irq_en_q  <= 1'b1;
            raise_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_data_q <= 8'd0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            presc_q   <= presc_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            irq_en_q  <= irq_en_d;
            raise_q   <= raise_d;
            rd_en_q   <= rd_en_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_ir_receiver_bus.sv
// tb/tb_ir_receiver_bus.sv - self-checking bench for ir_receiver_bus
module tb_ir_receiver_bus;

    localparam int         START_MIN = 2000;
    localparam int         BIT_MIN   = 200;
    localparam int         ONE_MIN   = 800;
    localparam int         BIT_MAX   = 1500;
    localparam int         GAP_MAX   = 1500;
    localparam logic [7:0] BASE      = 8'hA0;
    localparam logic [7:0] CTRL      = 8'hA1;
    localparam logic [7:0] IDLE_ADDR = 8'h00;
    localparam logic [7:0] RELEASED  = 8'hFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    wire  [7:0] bus_data;
    logic [7:0] bus_addr = IDLE_ADDR;
    logic       bus_we = 1'b0;
    logic       ir_rx = 1'b1;
    logic       irq;
    logic       ack = 1'b0;
    logic       tb_drive = 1'b0;
    logic [7:0] tb_wdata = 8'h00;

    int checks = 0;
    int errors = 0;

    // Reference model of the bus-visible state
    logic [3:0] m_data    = 4'd0;
    logic       m_valid   = 1'b0;
    logic       m_overrun = 1'b0;
    logic       m_raise   = 1'b0;
    logic       m_irq_en  = 1'b1;

    assign bus_data = tb_drive ? tb_wdata : 8'bz;

    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup pu (bus_data[g]);
    end

    always #5 clk = ~clk;

    ir_receiver_bus #(.TICK_DIV(1)) dut (
        .CLK                 (clk),
        .RESET               (rst_n),
        .BUS_DATA            (bus_data),
        .BUS_ADDR            (bus_addr),
        .BUS_WE              (bus_we),
        .IR_RX               (ir_rx),
        .BUS_INTERRUPT_RAISE (irq),
        .BUS_INTERRUPT_ACK   (ack)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic burst(input int on_len, input int off_len);
        ir_rx = 1'b0;
        repeat (on_len) @(negedge clk);
        ir_rx = 1'b1;
        repeat (off_len) @(negedge clk);
    endtask

    task automatic send_frame(input int st, input int bl[4], input int gp, input int tail);
        burst(st, gp);
        for (int i = 0; i < 4; i++) burst(bl[i], (i == 3) ? tail : gp);
    endtask

    // Frame meaning from the burst widths alone: thresholds, then bit = long burst
    function automatic logic decode(input int st, input int bl[4], input int gp,
                                    output logic [3:0] v);
        logic ok;
        ok = (st >= START_MIN) && (gp <= GAP_MAX);
        for (int i = 0; i < 4; i++) begin
            if (bl[i] < BIT_MIN || bl[i] > BIT_MAX) ok = 1'b0;
            v[3-i] = (bl[i] >= ONE_MIN);
        end
        return ok;
    endfunction

    task automatic model_frame(input logic ok, input logic [3:0] v);
        if (ok) begin
            if (m_valid) m_overrun = 1'b1;
            m_valid = 1'b1;
            m_data  = v;
            if (m_irq_en) m_raise = 1'b1;
        end
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        bus_addr = a;
        bus_we   = 1'b0;
        @(negedge clk);
        d        = bus_data;
        bus_addr = IDLE_ADDR;
        @(negedge clk);
        chk("bus_release", bus_data, RELEASED);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_addr = a;
        bus_we   = 1'b1;
        tb_wdata = d;
        tb_drive = 1'b1;
        @(negedge clk);
        bus_we   = 1'b0;
        bus_addr = IDLE_ADDR;
        tb_drive = 1'b0;
    endtask

    task automatic check_status(input string tag);
        logic [7:0] d;
        bus_read(CTRL, d);
        chk(tag, d, {4'b0, m_irq_en, 1'b0, m_overrun, m_valid});
        chk("irq_level", {7'b0, irq}, {7'b0, m_raise});
    endtask

    task automatic read_data(input string tag);
        logic [7:0] d;
        bus_read(BASE, d);
        chk(tag, d, {4'b0, m_data});
        m_valid   = 1'b0;
        m_overrun = 1'b0;
    endtask

    task automatic ack_irq();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        m_raise = 1'b0;
        chk("ack_clear", {7'b0, irq}, 8'h00);
    endtask

    initial begin
        int         bl[4];
        int         st, gp, n;
        logic [3:0] v;
        logic       ok;
        logic [7:0] d;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        chk("rst_bus", bus_data, RELEASED);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_status("status_after_reset");

        // Reset in the middle of a start burst discards the frame
        ir_rx = 1'b0;
        repeat (1000) @(negedge clk);
        bus_read(CTRL, d);
        chk("status_busy", d, 8'h0C);
        rst_n = 1'b0;
        ir_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("midreset_irq", {7'b0, irq}, 8'h00);
        chk("midreset_bus", bus_data, RELEASED);
        check_status("status_midreset");

        // Valid frame 1010
        st = 2500; gp = 500;
        bl = '{1000, 300, 1000, 300};
        ok = decode(st, bl, gp, v);
        send_frame(st, bl, gp, 0);
        n = 0;
        while (!irq && n < 8) begin
            @(negedge clk);
            n++;
        end
        model_frame(ok, v);
        chk("raise_latency_ok", {7'b0, (n <= 4)}, 8'h01);
        chk("raise_frame1", {7'b0, irq}, {7'b0, m_raise});
        check_status("status_frame1");
        read_data("data_frame1");
        check_status("status_after_read1");
        ack_irq();

        // Frame completing on the same edge as ACK keeps the interrupt
        st = 2100; gp = 300;
        bl = '{300, 1000, 300, 1000};
        ok = decode(st, bl, gp, v);
        send_frame(st, bl, gp, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        model_frame(ok, v);
        chk("raise_ack_coincide", {7'b0, irq}, 8'h01);
        repeat (2) @(negedge clk);
        chk("raise_hold", {7'b0, irq}, {7'b0, m_raise});

        // Second unread frame sets OVERRUN
        bl = '{300, 300, 1000, 1000};
        ok = decode(st, bl, gp, v);
        send_frame(st, bl, gp, 10);
        model_frame(ok, v);
        check_status("status_overrun");
        read_data("data_overrun");
        check_status("status_overrun_cleared");
        ack_irq();

        // Abort: short start burst
        burst(1500, 20);
        check_status("abort_start");

        // Abort: over-long gap after the second bit
        burst(2100, 300);
        burst(1000, 300);
        burst(300, 1600);
        burst(1000, 300);
        burst(300, 20);
        check_status("abort_gap");

        // Abort: glitch-length data burst
        burst(2100, 300);
        burst(100, 300);
        burst(1000, 300);
        burst(300, 300);
        burst(1000, 20);
        check_status("abort_glitch");

        // Interrupt disabled: frame is latched without an interrupt
        bus_write(CTRL, 8'h00);
        m_irq_en = 1'b0;
        check_status("status_irq_off");
        bl = '{1000, 1000, 300, 1000};
        ok = decode(st, bl, gp, v);
        send_frame(st, bl, gp, 10);
        model_frame(ok, v);
        check_status("status_irq_off_frame");
        bus_write(BASE, 8'hFF);
        bus_read(8'h55, d);
        chk("unmapped_read", d, RELEASED);
        read_data("data_irq_off");
        bus_write(CTRL, 8'h01);
        m_irq_en = 1'b1;

        // Control bit1 clears VALID
        bl = '{1000, 300, 300, 300};
        ok = decode(st, bl, gp, v);
        send_frame(st, bl, gp, 10);
        model_frame(ok, v);
        check_status("status_before_ctrl_clear");
        bus_write(CTRL, 8'h03);
        m_valid   = 1'b0;
        m_overrun = 1'b0;
        check_status("status_ctrl_clear");
        ack_irq();

        // Randomized frames with random read/ack behaviour
        for (int k = 0; k < 4; k++) begin
            st = $urandom_range(2300, 2010);
            gp = $urandom_range(300, 50);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(1, 0) == 1) bl[i] = $urandom_range(950, 810);
                else                           bl[i] = $urandom_range(600, 210);
            end
            ok = decode(st, bl, gp, v);
            send_frame(st, bl, gp, 10);
            model_frame(ok, v);
            check_status("status_random");
            if ($urandom_range(1, 0) == 1) read_data("data_random");
            if ($urandom_range(1, 0) == 1) ack_irq();
        end
        read_data("data_final");
        check_status("status_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
